// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle AND/OR/ADD plus iterative MUL/MULHU/DIVU/REMU behind a valid/ready handshake.
// Define ALU_FLAGS_EN to add registered carry/overflow outputs for ADD.
module alu_multicycle #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
`ifdef ALU_FLAGS_EN
   output logic             carry,
   output logic             overflow,
`endif
   output logic             zero
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, nextState;
   logic               accept;
   logic               isMulti;
   logic               lastStep;
   logic [1:0]         opReg;
   logic [WIDTH-1:0]   bReg;
   logic [WIDTH-1:0]   hi, lo;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   opA, opB, addSum, singleResult;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     remShift;
   logic [WIDTH-1:0]   remDiff;
   logic               ge;
   logic [WIDTH-1:0]   stepHi, stepLo, finalResult;

   assign isMulti  = (ALUOp[1:0] == 2'b11);
   assign lastStep = (cnt == CNT_W'(WIDTH - 1));
   assign opA      = ALUOp[3] ? ~a : a;
   assign opB      = ALUOp[2] ? ~b : b;

`ifdef ALU_FLAGS_EN
   logic addCarry;
   assign {addCarry, addSum} = {1'b0, opA} + {1'b0, opB};
`else
   assign addSum = opA + opB;
`endif

   always_comb begin
      singleResult = addSum;
      case (ALUOp[1:0])
         2'b00:   singleResult = opA & opB;
         2'b01:   singleResult = opA | opB;
         default: singleResult = addSum;
      endcase
   end

   // {hi,lo} is the product register for MUL and {remainder,quotient} for divide.
   // The subtraction only matters when ge holds, so the dropped top bit is always zero.
   assign mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, bReg} : '0);
   assign remShift = {hi, lo[WIDTH-1]};
   assign ge       = (remShift >= {1'b0, bReg});
   assign remDiff  = remShift[WIDTH-1:0] - bReg;

   always_comb begin
      stepHi      = mulSum[WIDTH:1];
      stepLo      = {mulSum[0], lo[WIDTH-1:1]};
      finalResult = stepLo;
      if (opReg[1]) begin
         stepHi = ge ? remDiff : remShift[WIDTH-1:0];
         stepLo = {lo[WIDTH-2:0], ge};
      end
      case (opReg)
         2'b01, 2'b11: finalResult = stepHi;
         default:      finalResult = stepLo;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state and handshake outputs
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      case (state)
         IDLE: if (in_valid) begin
            accept    = 1'b1;
            nextState = isMulti ? BUSY : DONE;
         end
         BUSY: if (lastStep) nextState = DONE;
         DONE: if (out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         opReg  <= '0;
         bReg   <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         Result <= '0;
         zero   <= 1'b0;
`ifdef ALU_FLAGS_EN
         carry    <= 1'b0;
         overflow <= 1'b0;
`endif
      end else if (accept) begin
         if (isMulti) begin
            opReg <= ALUOp[3:2];
            bReg  <= b;
            hi    <= '0;
            lo    <= a;
            cnt   <= '0;
         end else begin
            Result <= singleResult;
            zero   <= (singleResult == '0);
`ifdef ALU_FLAGS_EN
            carry    <= (ALUOp[1:0] == 2'b10) && addCarry;
            overflow <= (ALUOp[1:0] == 2'b10) && (opA[WIDTH-1] == opB[WIDTH-1])
                        && (addSum[WIDTH-1] != opA[WIDTH-1]);
`endif
         end
      end else if (state == BUSY) begin
         hi  <= stepHi;
         lo  <= stepLo;
         cnt <= cnt + CNT_W'(1);
         if (lastStep) begin
            Result <= finalResult;
            zero   <= (finalResult == '0);
`ifdef ALU_FLAGS_EN
            carry    <= 1'b0;
            overflow <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle at WIDTH=64 and WIDTH=8 against a plain-arithmetic model.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        validBus = 1'b0;
   logic        outReady = 1'b0;
   logic [63:0] aBus = '0, bBus = '0;
   logic [3:0]  opBus = '0;
   int          sel = 0;
   int          errors = 0;
   int          checks = 0;

   logic        ir64, ov64, z64, ir8, ov8, z8;
   logic [63:0] res64;
   logic [7:0]  res8;
   logic        c64, v64, c8, v8;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .in_valid(validBus && sel == 0), .in_ready(ir64),
      .a(aBus), .b(bBus), .ALUOp(opBus), .out_valid(ov64), .out_ready(outReady),
      .Result(res64),
`ifdef ALU_FLAGS_EN
      .carry(c64), .overflow(v64),
`endif
      .zero(z64));

   alu_multicycle #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(validBus && sel == 1), .in_ready(ir8),
      .a(aBus[7:0]), .b(bBus[7:0]), .ALUOp(opBus), .out_valid(ov8), .out_ready(outReady),
      .Result(res8),
`ifdef ALU_FLAGS_EN
      .carry(c8), .overflow(v8),
`endif
      .zero(z8));

`ifndef ALU_FLAGS_EN
   assign {c64, v64, c8, v8} = '0;
`endif

   logic        irObs, ovObs, zObs, cObs, vObs;
   logic [63:0] resObs;
   assign irObs  = (sel == 1) ? ir8 : ir64;
   assign ovObs  = (sel == 1) ? ov8 : ov64;
   assign zObs   = (sel == 1) ? z8  : z64;
   assign cObs   = (sel == 1) ? c8  : c64;
   assign vObs   = (sel == 1) ? v8  : v64;
   assign resObs = (sel == 1) ? {56'b0, res8} : res64;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned arithmetic on w-bit values using wide integers
   function automatic logic [63:0] refModel(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                                            input int w, output logic c, output logic v);
      logic [63:0]  mask, aa, bb, ia, ib, res;
      logic [127:0] wide;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      aa = av & mask;
      bb = bv & mask;
      ia = (op[3] ? ~aa : aa) & mask;
      ib = (op[2] ? ~bb : bb) & mask;
      c = 1'b0;
      v = 1'b0;
      res = '0;
      case (op[1:0])
         2'b00: res = ia & ib;
         2'b01: res = ia | ib;
         2'b10: begin
            wide = {64'b0, ia} + {64'b0, ib};
            res  = wide[63:0] & mask;
            c    = wide[w];
            v    = (ia[w-1] == ib[w-1]) && (wide[w-1] != ia[w-1]);
         end
         default: begin
            wide = {64'b0, aa} * {64'b0, bb};
            case (op[3:2])
               2'b00: res = wide[63:0] & mask;
               2'b01: res = 64'(wide >> w) & mask;
               2'b10: res = (bb == 0) ? mask : aa / bb;
               default: res = (bb == 0) ? aa : aa % bb;
            endcase
         end
      endcase
      return res;
   endfunction

   task automatic applyStimulus(input int s, input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                                input int stall, input string tag);
      int          w, lat;
      logic [63:0] exp;
      logic        ec, ev, bad;
      w   = (s == 1) ? 8 : 64;
      exp = refModel(op, av, bv, w, ec, ev);
      @(negedge clk);
      sel = s; aBus = av; bBus = bv; opBus = op; validBus = 1'b1;
      #1;
      checkOutput({tag, ".ready"}, 64'(irObs), 64'd1);
      @(posedge clk); #1;
      validBus = 1'b0;
      aBus = {$urandom, $urandom}; bBus = {$urandom, $urandom}; opBus = 4'($urandom);
      lat = 0;
      bad = 1'b0;
      while (!ovObs && lat < 200) begin
         if (irObs) bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, ".lat"}, 64'(lat), (op[1:0] == 2'b11) ? 64'(w) : 64'd0);
      checkOutput({tag, ".busyReady"}, 64'(bad), 64'd0);
      checkOutput({tag, ".res"}, resObs, exp);
      checkOutput({tag, ".zero"}, 64'(zObs), 64'(exp == 64'd0));
`ifdef ALU_FLAGS_EN
      checkOutput({tag, ".flags"}, {62'b0, cObs, vObs}, {62'b0, ec, ev});
`endif
      bad = irObs;
      repeat (stall) begin
         @(posedge clk); #1;
         if (!ovObs || resObs !== exp || irObs) bad = 1'b1;
      end
      checkOutput({tag, ".hold"}, 64'(bad), 64'd0);
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput({tag, ".idle"}, {62'b0, ovObs, irObs}, 64'b01);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst64", {res64, 60'b0, ir64, ov64, z64, 1'b0}, {64'd0, 60'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      checkOutput("rst8", {56'b0, res8, ir8, ov8, z8}, {56'b0, 8'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(0, 4'b0010, 64'd5, 64'd3, 0, "add53");
      applyStimulus(0, 4'b0110, 64'd7, 64'd7, 0, "addInvB");
      applyStimulus(0, 4'b0000, 64'd0, 64'd0, 0, "andZero");
      applyStimulus(0, 4'b0011, {64{1'b1}}, 64'd2, 5, "mulMax");
      applyStimulus(0, 4'b0111, {64{1'b1}}, 64'd2, 0, "mulhuMax");
      applyStimulus(1, 4'b1011, 64'd100, 64'd7, 0, "divu8");
      applyStimulus(1, 4'b1111, 64'd100, 64'd7, 0, "remu8");
      applyStimulus(1, 4'b1011, 64'd100, 64'd0, 0, "divu8z");
      applyStimulus(1, 4'b1111, 64'd100, 64'd0, 2, "remu8z");
      applyStimulus(0, 4'b1011, 64'd12345, 64'd0, 0, "divu64z");

      // Reset in the middle of a 64-bit multiply
      @(negedge clk);
      sel = 0; aBus = {$urandom, $urandom}; bBus = {$urandom, $urandom}; opBus = 4'b0011; validBus = 1'b1;
      @(posedge clk); #1;
      validBus = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midReset", {res64, 61'b0, ov64, ir64, z64}, {64'd0, 61'b0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 4'b0010, 64'd1, 64'd1, 0, "addAfterRst");

      for (int i = 0; i < 30; i++) begin
         logic [63:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 60);
         applyStimulus(i % 2, 4'($urandom), ra, rb, $urandom_range(0, 2), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
